// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : UART receive controller. Drives the external edge/bit
//                counter enable, majority-votes three mid-bit samples of
//                RX_IN, deserializes LSB-first and checks start, parity and
//                stop bits. Good bytes are delivered with a Data_Valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int Data_Width = 8,
    parameter int B_C_W      = $clog2(Data_Width + 4)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Edge_Count,
    input  logic [B_C_W-1:0]      Bit_Count,
    output logic                  Cnt_En,
    output logic [Data_Width-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Bit_Count value of the last data bit
    localparam logic [B_C_W-1:0] c_last_data_idx = B_C_W'(Data_Width);

    state_t                r_state;
    logic [Data_Width-1:0] r_shift;
    logic                  r_par_err;
    logic                  r_samp0;
    logic                  r_samp1;
    logic                  r_samp2;

    logic [5:0]            w_mid;
    logic                  w_last;
    logic                  w_at_samp0;
    logic                  w_at_samp1;
    logic                  w_at_samp2;
    logic                  w_at_stop_eval;
    logic                  w_vote;
    logic                  w_exp_par;
    logic [Data_Width:0]   w_shift_cat;
    logic [Data_Width-1:0] w_shift_nxt;

    assign w_mid          = {1'b0, Prescale[5:1]};
    assign w_last         = (Edge_Count == (Prescale - 6'd1));
    assign w_at_samp0     = (Edge_Count == (w_mid - 6'd1));
    assign w_at_samp1     = (Edge_Count == w_mid);
    assign w_at_samp2     = (Edge_Count == (w_mid + 6'd1));
    // Stop bit is judged early so the FSM is idle before the next start bit
    assign w_at_stop_eval = (Edge_Count == (w_mid + 6'd2));

    // Any single corrupted sample is outvoted by the other two
    assign w_vote    = (r_samp0 & r_samp1) | (r_samp0 & r_samp2) | (r_samp1 & r_samp2);
    assign w_exp_par = (^r_shift) ^ PAR_TYP;

    // Right shift with the new bit entering at the MSB (LSB-first line order)
    assign w_shift_cat = {w_vote, r_shift};
    assign w_shift_nxt = w_shift_cat[Data_Width:1];

    // Capture RX_IN at the three sample points around mid-bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samp0 <= 1'b0;
            r_samp1 <= 1'b0;
            r_samp2 <= 1'b0;
        end else if (Cnt_En) begin
            if (w_at_samp0) r_samp0 <= RX_IN;
            if (w_at_samp1) r_samp1 <= RX_IN;
            if (w_at_samp2) r_samp2 <= RX_IN;
        end
    end

    // Frame state machine with registered counter enable and result pulses
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            Cnt_En       <= 1'b0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
        end else begin
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!RX_IN) begin
                        r_state   <= START;
                        Cnt_En    <= 1'b1;
                        r_par_err <= 1'b0;
                    end
                end
                START: begin
                    if (w_last) begin
                        if (w_vote) begin
                            // line was high at mid-bit: glitch, not a start bit
                            r_state <= IDLE;
                            Cnt_En  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_last) begin
                        r_shift <= w_shift_nxt;
                        if (Bit_Count == c_last_data_idx) begin
                            r_state <= PAR_EN ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_last) begin
                        r_par_err <= (w_vote != w_exp_par);
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_at_stop_eval) begin
                        r_state <= IDLE;
                        Cnt_En  <= 1'b0;
                        if (r_par_err || !w_vote) begin
                            Parity_Error <= r_par_err;
                            Stop_Error   <= ~w_vote;
                        end else begin
                            P_DATA     <= r_shift;
                            Data_Valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    Cnt_En  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_ctrl
//  Description : Self-checking bench for uart_rx_ctrl with an edge/bit counter
//                fixture, frame waveform builder and outcome reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Edge_Count;
    logic [3:0] Bit_Count;
    logic       Cnt_En;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Parity_Error;
    logic       Stop_Error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         at;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } ev_t;

    ev_t        evq[$];
    logic       wave[$];
    logic [7:0] model_pd;

    uart_rx_ctrl #(.Data_Width(8), .B_C_W(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .Edge_Count   (Edge_Count),
        .Bit_Count    (Bit_Count),
        .Cnt_En       (Cnt_En),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Upstream edge/bit counter fixture
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Edge_Count <= 6'd0;
            Bit_Count  <= 4'd0;
        end else if (!Cnt_En) begin
            Edge_Count <= 6'd0;
            Bit_Count  <= 4'd0;
        end else if (Edge_Count == (Prescale - 6'd1)) begin
            Edge_Count <= 6'd0;
            Bit_Count  <= Bit_Count + 4'd1;
        end else begin
            Edge_Count <= Edge_Count + 6'd1;
        end
    end

    // Log every output pulse with the cycle index it is visible in
    always @(negedge CLK) begin
        if ((Data_Valid | Parity_Error | Stop_Error) === 1'b1)
            evq.push_back('{cyc + 1, Data_Valid, Parity_Error, Stop_Error, P_DATA});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outcome of a frame from its line bits: {data_valid, parity_err, stop_err}
    function automatic logic [2:0] outcome(input logic [7:0] d, input logic pen,
                                           input logic ptyp, input logic pbit, input logic sbit);
        logic pe;
        logic se;
        pe = pen && (pbit != ((^d) ^ ptyp));
        se = !sbit;
        return {!(pe || se), pe, se};
    endfunction

    // Append one frame to the line waveform; gk/ge pick a bit and sample edge to glitch
    task automatic add_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic sbit, input int gk, input int ge);
        int   p;
        logic bits[$];
        p = int'(Prescale);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(sbit);
        for (int k = 0; k < bits.size(); k++)
            for (int j = 0; j < p; j++)
                wave.push_back((k == gk && j == ge + 1) ? ~bits[k] : bits[k]);
    endtask

    task automatic play(input int n);
        int cnt = 0;
        while (wave.size() > 0 && (n < 0 || cnt < n)) begin
            RX_IN = wave.pop_front();
            @(negedge CLK);
            cnt++;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_to(input int n, input string tag);
        int budget = 20000;
        while (cyc + 1 < n && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (budget == 0) begin
            total++;
            bad++;
            $error("FAIL %s: wait timed out at cycle %0d, target %0d", tag, cyc, n);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input int at,
                            input logic [2:0] kind, input logic [7:0] pd);
        if (evq.size() > idx) begin
            chk({tag, ".when"},  32'(evq[idx].at), 32'(at));
            chk({tag, ".kind"},  32'({evq[idx].dv, evq[idx].pe, evq[idx].se}), 32'(kind));
            chk({tag, ".pdata"}, 32'(evq[idx].pd), 32'(pd));
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] d, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit,
                            input int gk, input int ge);
        int         t;
        int         p;
        int         at;
        logic [2:0] k;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        p = int'(Prescale);
        add_frame(d, pen, pbit, sbit, gk, ge);
        t = cyc + 1;
        play(-1);
        RX_IN = 1'b1;
        k  = outcome(d, pen, ptyp, pbit, sbit);
        at = t + 2 + (9 + int'(pen)) * p + p / 2 + 2;
        if (k[2]) model_pd = d;
        wait_to(at + 1, tag);
        #1;
        chk({tag, ".count"}, 32'(evq.size()), 32'd1);
        check_ev(tag, 0, at, k, model_pd);
        chk({tag, ".P_DATA"}, 32'(P_DATA), 32'(model_pd));
        evq.delete();
        idle(3 * p);
    endtask

    initial begin
        int t;
        int t1;
        int at1;
        int at2;
        int p;
        logic [7:0] d;
        logic pen;
        logic ptyp;
        logic pbit;
        logic sbit;
        int gk;
        int ge;

        // Reset held while the line toggles
        RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        model_pd = 8'h00;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 12; i++) begin
            RX_IN = 1'($urandom % 2);
            @(negedge CLK);
            chk("rst_hold", 32'({Cnt_En, Data_Valid, Parity_Error, Stop_Error, P_DATA}), 32'd0);
        end
        RX_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        idle(30);
        #1;
        chk("post_rst.cnt_en", 32'(Cnt_En), 32'd0);
        chk("post_rst.events", 32'(evq.size()), 32'd0);
        evq.delete();
        idle(1);

        // Directed frames at Prescale 8
        Prescale = 6'd8;
        do_frame("good_a5",   8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
        do_frame("par_err",   8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0);
        do_frame("odd_good",  8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
        do_frame("stop_err",  8'h5B, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0);
        do_frame("nopar_good", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        do_frame("nopar_stop", 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0);

        // False start: line low for only three cycles
        t = cyc + 1;
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        wait_to(t + 8, "false_start");
        chk("false_start.cnt_en_hi", 32'(Cnt_En), 32'd1);
        chk("false_start.edge",      32'(Edge_Count), 32'd7);
        chk("false_start.bit",       32'(Bit_Count), 32'd0);
        @(negedge CLK);
        chk("false_start.cnt_en_lo", 32'(Cnt_En), 32'd0);
        idle(20);
        #1;
        chk("false_start.events", 32'(evq.size()), 32'd0);
        evq.delete();
        idle(1);

        // Back-to-back frames at Prescale 16 with mid-sample glitches
        Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        add_frame(8'h3C, 1'b0, 1'b0, 1'b1, 3, 8);
        add_frame(8'hC3, 1'b0, 1'b0, 1'b1, 6, 8);
        t1 = cyc + 1;
        play(-1);
        RX_IN = 1'b1;
        at1 = t1 + 2 + 9 * 16 + 8 + 2;
        at2 = at1 + 10 * 16;
        wait_to(at2 + 1, "b2b");
        #1;
        chk("b2b.count", 32'(evq.size()), 32'd2);
        check_ev("b2b.first",  0, at1, 3'b100, 8'h3C);
        check_ev("b2b.second", 1, at2, 3'b100, 8'hC3);
        model_pd = 8'hC3;
        chk("b2b.P_DATA", 32'(P_DATA), 32'hC3);
        evq.delete();
        idle(48);

        // Reset asserted during data bit 4
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        add_frame(8'h96, 1'b1, 1'b0, 1'b1, -1, 0);
        play(5 * 8 + 4);
        wave.delete();
        RST = 1'b0;
        RX_IN = 1'b1;
        #1;
        chk("rst_mid.outputs", 32'({Cnt_En, Data_Valid, Parity_Error, Stop_Error, P_DATA}), 32'd0);
        model_pd = 8'h00;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        idle(40);
        #1;
        chk("rst_mid.events", 32'(evq.size()), 32'd0);
        chk("rst_mid.cnt_en", 32'(Cnt_En), 32'd0);
        evq.delete();
        idle(1);
        do_frame("after_rst", 8'h69, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);

        // Randomized frames against the outcome model
        for (int i = 0; i < 12; i++) begin
            case ($urandom % 3)
                0:       Prescale = 6'd8;
                1:       Prescale = 6'd16;
                default: Prescale = 6'd32;
            endcase
            p    = int'(Prescale);
            d    = 8'($urandom);
            pen  = 1'($urandom % 2);
            ptyp = 1'($urandom % 2);
            pbit = (^d) ^ ptyp ^ (($urandom % 4) == 0);
            sbit = (($urandom % 5) != 0);
            gk   = int'($urandom_range(0, 9 + int'(pen)));
            ge   = p / 2 - 1 + int'($urandom_range(0, 2));
            do_frame($sformatf("rand%0d", i), d, pen, ptyp, pbit, sbit, gk, ge);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller. It sits directly downstream of the RX edge/bit counter: it consumes that counter's `Edge_Count`/`Bit_Count` and drives the counter's enable. It also oversamples `RX_IN` with a 3-sample majority vote, deserializes the frame LSB-first, and checks start, parity and stop bits. It delivers each good byte with a one-cycle `Data_Valid` pulse.

## Interface
- `Data_Width`, default 8: number of data bits per frame.
- `B_C_W`, default `$clog2(Data_Width+4)`: `Bit_Count` width. Must equal the counter's width.
- `CLK` in 1: system (oversampling) clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `RX_IN` in 1: serial line; idles high.
- `Prescale` in 6: oversampling ratio. Legal values are 8, 16, 32 and are static while a frame is in flight.
- `PAR_EN` in 1: 1 means a parity bit follows the data bits.
- `PAR_TYP` in 1: 0 means even parity, 1 means odd parity.
- `Edge_Count` in 6: counter input. Counts 0..Prescale-1, then wraps.
- `Bit_Count` in B_C_W: counter input. Increments on each `Edge_Count` wrap.
- `Cnt_En` out 1: counter enable. While low, the counter holds both counts at 0.
- `P_DATA` out Data_Width: last good frame's data.
- `Data_Valid` out 1: one-cycle pulse when `P_DATA` is updated with a good frame.
- `Parity_Error` out 1: one-cycle pulse for a frame with bad parity.
- `Stop_Error` out 1: one-cycle pulse for a frame with a bad stop bit.

## Operation
- Definitions:
  - `mid` = Prescale/2.
  - `last` = Edge_Count == Prescale-1.
  - `vote` = majority of three flops capturing `RX_IN` at Edge_Count mid-1, mid, mid+1. `vote` is valid for Edge_Count ≥ mid+2.
- Frame bit indices by `Bit_Count`:
  - 0: start bit.
  - 1..Data_Width: data, LSB first.
  - Data_Width+1: parity bit, only if PAR_EN.
  - Next index: stop bit, S = Data_Width+1+PAR_EN.
- States (one-hot or binary): IDLE, START, DATA, PARITY, STOP.
- `Cnt_En` is a Moore output: 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- IDLE: when `RX_IN`=0 at a clock edge, go to START.
- START, at `last`:
  - vote=1: false start, go to IDLE. No outputs pulse.
  - vote=0: go to DATA.
- DATA, at `last`:
  - Shift vote into the internal shift register at the MSB, shifting right.
  - When Bit_Count == Data_Width: go to PARITY if PAR_EN, else go to STOP.
- PARITY, at `last`:
  - par_err = vote ≠ (^shift_reg ^ PAR_TYP).
  - Latch par_err internally and go to STOP.
- STOP:
  - Evaluated at Edge_Count == mid+2, not at `last`, so the FSM is back in IDLE before the next start bit.
  - stop_err = (vote == 0).
  - Go to IDLE.
  - Next cycle: if par_err or stop_err is set, pulse the matching error outputs (both can pulse together). Otherwise load `P_DATA` from the shift register and pulse `Data_Valid`.
- `P_DATA` changes only on a good frame. Errored frames never overwrite it.
- The par_err latch clears on entry to START.
- When PAR_EN=0, `Parity_Error` never pulses.
- Reset values:
  - State IDLE.
  - `Cnt_En`=0, `P_DATA`=0, `Data_Valid`=0, `Parity_Error`=0, `Stop_Error`=0.
  - Shift register, vote flops and par_err all 0.
- Asserting reset mid-frame aborts the frame immediately with no pulses. After release, the FSM waits in IDLE for a fresh falling edge.

## Timing
- Reference point: `RX_IN` is first seen low at clock edge t.
  - State is START from t+1, with Edge_Count=0 at t+1.
  - Bit k, edge e occurs in cycle t+1+k·Prescale+e.
- `Data_Valid`/error pulse cycle = t+2+S·Prescale+mid+2.
  - Prescale=8, D=8, PAR_EN=1: t+88.
  - Prescale=8, D=8, PAR_EN=0: t+80.
- All decisions in the current state use the `Edge_Count`/`Bit_Count` values of that cycle. State changes take effect on the next edge.
- `Cnt_En` falls on the same edge the state enters IDLE, so the counter is back at 0 one cycle later.
- Back-to-back frames: the next start bit may begin as early as the end of the stop-bit period. The minimum stop length is 1 bit.
- A single-cycle glitch on any one of the three sample points must not change `vote`.

## Test plan
- Reset: hold RST=0 while toggling RX_IN. Required: all outputs 0 and Cnt_En=0 throughout. After release, with RX_IN high, the FSM stays in IDLE.
- Good frame: Prescale=8, PAR_EN=1, PAR_TYP=0, data 8'hA5, parity bit 0, stop 1. Required: Data_Valid for exactly one cycle at t+88, P_DATA=8'hA5, no error pulses.
- Parity error: same frame with parity bit 1. Required: Parity_Error pulses at t+88, P_DATA keeps its old value, Data_Valid stays 0. Then PAR_TYP=1 with parity bit 1: Data_Valid pulses.
- Stop error and false start:
  - Stop bit driven 0: Stop_Error pulses.
  - RX_IN low for only 3 cycles: FSM returns to IDLE at Bit_Count 0, edge 7, with no pulses.
- Back-to-back and glitch: Prescale=16, PAR_EN=0, frames 8'h3C then 8'hC3 with a 1-bit stop, plus a 1-cycle inverted glitch at sample point mid. Required: two Data_Valid pulses with P_DATA 8'h3C then 8'hC3.
- Reset mid-frame: RST=0 during data bit 4. Required: immediate IDLE, Cnt_En=0, no pulses. The next complete frame is received correctly.
